spi_slave_phy: RTL and testbench

SPI slave physical layer that oversamples SCK/CS_N/MOSI in the system clock domain. It deserialises MOSI bytes into a framed receive stream and serialises bytes from a one-deep transmit holding register onto MISO. It sits between an external SPI master and the internal packet/command logic. Mode is selected by parameters; bytes are MSB first.

---
 rtl/spi_slave_phy.sv | 175 +++++++++++++++++
 tb/tb_spi_slave_phy.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_phy.sv
// SPI slave PHY: synchronises SCK/CS_N/MOSI into the system clock domain,
// deserialises MOSI bytes into a framed RX stream and serialises a one-deep
// TX holding register onto MISO. MSB first; CPOL/CPHA set by parameters.
module spi_slave_phy #(
  parameter int unsigned PHASE  = 1,
  parameter int unsigned ACTIVE = 0
) (
  input  logic        clock,
  input  logic        rst_n,
  input  logic        sck,
  input  logic        cs_n,
  input  logic        mosi,
  output logic        miso,
  output logic        rx_stream_sof,
  output logic [7:0]  rx_stream_data,
  output logic        rx_stream_vld,
  output logic        rx_stream_eof,
  output logic        tx_send_flag,
  input  logic [23:0] tx_send_momment,
  input  logic [7:0]  tx_send_data,
  input  logic        tx_send_valid,
  output logic        tx_empty
);

  localparam int unsigned CNT_W    = 24;
  localparam logic        IDLE_SCK = (ACTIVE != 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [1:0]       sck_s;
  logic [1:0]       cs_s;
  logic [1:0]       mosi_s;
  logic             sck_d;
  logic             cs_d;
  logic [1:0]       settle;
  logic             armed;

  logic [6:0]       rx_shift;
  logic [2:0]       bit_cnt;
  logic [CNT_W-1:0] byte_cnt;

  logic [7:0]       tx_shift;
  logic [2:0]       tx_bit;
  logic [7:0]       hold_q;

  logic             in_frame;
  logic             cs_fall;
  logic             cs_rise;
  logic             lead;
  logic             trail;
  logic             sample_edge;
  logic             shift_edge;
  logic             tx_load;
  logic [CNT_W-1:0] load_cnt;
  logic             use_hold;
  logic [7:0]       load_byte;

  // Two-flop synchronisers plus one delayed copy for edge detection.
  // 'armed' blocks a false frame start when cs_n is already low at reset release.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      sck_s  <= {IDLE_SCK, IDLE_SCK};
      cs_s   <= 2'b11;
      mosi_s <= 2'b00;
      sck_d  <= IDLE_SCK;
      cs_d   <= 1'b1;
      settle <= 2'b00;
      armed  <= 1'b0;
    end else begin
      sck_s  <= {sck_s[0], sck};
      cs_s   <= {cs_s[0], cs_n};
      mosi_s <= {mosi_s[0], mosi};
      sck_d  <= sck_s[1];
      cs_d   <= cs_s[1];
      settle <= {settle[0], 1'b1};
      if (settle[1] && cs_s[1]) begin
        armed <= 1'b1;
      end
    end
  end

  // Frame/edge decode and TX load-source selection.
  always_comb begin
    in_frame    = armed & ~cs_s[1];
    cs_fall     = armed & cs_d & ~cs_s[1];
    cs_rise     = armed & ~cs_d & cs_s[1];
    lead        = in_frame & (sck_d == IDLE_SCK) & (sck_s[1] != IDLE_SCK);
    trail       = in_frame & (sck_d != IDLE_SCK) & (sck_s[1] == IDLE_SCK);
    sample_edge = (PHASE == 0) ? lead : trail;
    shift_edge  = (PHASE == 0) ? trail : lead;
    if (PHASE == 0) begin
      tx_load = cs_fall | (shift_edge & (tx_bit == 3'd7));
    end else begin
      tx_load = shift_edge & (tx_bit == 3'd0);
    end
    load_cnt  = cs_fall ? '0 : byte_cnt;
    use_hold  = tx_load & ~tx_empty & (load_cnt >= tx_send_momment);
    load_byte = use_hold ? hold_q : 8'hFF;
  end

  // Frame markers.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rx_stream_sof <= 1'b0;
      rx_stream_eof <= 1'b0;
      tx_send_flag  <= 1'b0;
    end else begin
      rx_stream_sof <= cs_fall;
      rx_stream_eof <= cs_rise;
      tx_send_flag  <= in_frame;
    end
  end

  // RX deserialiser; a partial byte is dropped when the frame ends.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      rx_shift       <= '0;
      bit_cnt        <= '0;
      byte_cnt       <= '0;
      rx_stream_data <= '0;
      rx_stream_vld  <= 1'b0;
    end else begin
      rx_stream_vld <= 1'b0;
      if (cs_fall || cs_rise) begin
        bit_cnt <= '0;
        if (cs_fall) begin
          byte_cnt <= '0;
        end
      end else if (sample_edge) begin
        rx_shift <= {rx_shift[5:0], mosi_s[1]};
        bit_cnt  <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) begin
          rx_stream_data <= {rx_shift, mosi_s[1]};
          rx_stream_vld  <= 1'b1;
          if (byte_cnt != CNT_MAX) begin
            byte_cnt <= byte_cnt + CNT_W'(1);
          end
        end
      end
    end
  end

  // TX serialiser; MISO idles high outside a frame.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      miso     <= 1'b1;
      tx_shift <= '1;
      tx_bit   <= '0;
    end else if (!in_frame) begin
      miso   <= 1'b1;
      tx_bit <= '0;
    end else if (tx_load) begin
      miso     <= load_byte[7];
      tx_shift <= {load_byte[6:0], 1'b1};
      tx_bit   <= (PHASE == 0) ? 3'd0 : 3'd1;
    end else if (shift_edge) begin
      miso     <= tx_shift[7];
      tx_shift <= {tx_shift[6:0], 1'b1};
      tx_bit   <= tx_bit + 3'd1;
    end
  end

  // One-deep holding register; a write in the same cycle as a take refills it.
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      hold_q   <= '0;
      tx_empty <= 1'b1;
    end else if (tx_send_valid && (tx_empty || use_hold)) begin
      hold_q   <= tx_send_data;
      tx_empty <= 1'b0;
    end else if (use_hold) begin
      tx_empty <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_slave_phy.sv
// Bench for spi_slave_phy: four instances cover all CPOL/CPHA modes; a
// bit-banged SPI master, a TX feeder and a per-instance output monitor.
module tb_spi_slave_phy;

  localparam int H = 8;  // SCK half period in system clocks

  typedef struct {
    int              inst;
    int              n;
    logic [0:8][7:0] wr;
    int              mom;
    int              nfeed;
    logic [0:8][7:0] fd;
    logic [0:8][7:0] exp;
  } vec_t;

  logic        clock = 1'b0;
  logic        rst_n;
  logic        sck_v      [4];
  logic        cs_n_v     [4];
  logic        mosi_v     [4];
  logic        miso_v     [4];
  logic        sof_v      [4];
  logic        vld_v      [4];
  logic        eof_v      [4];
  logic        flag_v     [4];
  logic        tx_valid_v [4];
  logic        te_v       [4];
  logic [7:0]  rx_data_v  [4];
  logic [7:0]  tx_data_v  [4];
  logic [23:0] mom_v      [4];

  int checks = 0;
  int errors = 0;

  int         sof_cnt [4] = '{default: 0};
  int         eof_cnt [4] = '{default: 0};
  int         rx_cnt  [4] = '{default: 0};
  int         te_rise [4] = '{default: 0};
  logic       te_prev [4] = '{default: 1'b1};
  logic [7:0] rx_log  [4][128];

  int              cur = 1;
  logic            feed_en = 1'b0;
  int              feed_n = 0;
  int              feed_idx = 0;
  logic [0:8][7:0] feed_fd = '0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    spi_slave_phy #(.PHASE(g % 2), .ACTIVE(g / 2)) u_dut (
      .clock           (clock),
      .rst_n           (rst_n),
      .sck             (sck_v[g]),
      .cs_n            (cs_n_v[g]),
      .mosi            (mosi_v[g]),
      .miso            (miso_v[g]),
      .rx_stream_sof   (sof_v[g]),
      .rx_stream_data  (rx_data_v[g]),
      .rx_stream_vld   (vld_v[g]),
      .rx_stream_eof   (eof_v[g]),
      .tx_send_flag    (flag_v[g]),
      .tx_send_momment (mom_v[g]),
      .tx_send_data    (tx_data_v[g]),
      .tx_send_valid   (tx_valid_v[g]),
      .tx_empty        (te_v[g])
    );
  end

  // Output monitor: counts pulses and logs received bytes per instance.
  always @(negedge clock) begin
    for (int i = 0; i < 4; i++) begin
      if (sof_v[i]) sof_cnt[i] <= sof_cnt[i] + 1;
      if (eof_v[i]) eof_cnt[i] <= eof_cnt[i] + 1;
      if (vld_v[i]) begin
        rx_log[i][rx_cnt[i] % 128] <= rx_data_v[i];
        rx_cnt[i] <= rx_cnt[i] + 1;
      end
      if (te_v[i] && !te_prev[i]) te_rise[i] <= te_rise[i] + 1;
      te_prev[i] <= te_v[i];
    end
  end

  // TX feeder: writes the next queued byte whenever the holding register is empty.
  initial begin
    for (int i = 0; i < 4; i++) begin
      tx_valid_v[i] = 1'b0;
      tx_data_v[i]  = 8'h00;
    end
    forever begin
      @(negedge clock);
      for (int i = 0; i < 4; i++) tx_valid_v[i] = 1'b0;
      if (!feed_en) begin
        feed_idx = 0;
      end else if (te_v[cur] && feed_idx < feed_n) begin
        tx_data_v[cur]  = feed_fd[feed_idx];
        tx_valid_v[cur] = 1'b1;
        feed_idx++;
      end
    end
  end

  initial begin
    #3ms;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clock);
  endtask

  // Master transfers nb bits of wr MSB first and returns what it sampled on MISO.
  task automatic spi_byte(input int i, input logic [7:0] wr, input int nb, output logic [7:0] rd);
    logic act;
    act = (i >= 2);
    rd  = 8'h00;
    for (int b = 0; b < nb; b++) begin
      if (i % 2 == 0) begin
        mosi_v[i] = wr[7-b];
        wait_clk(H);
        sck_v[i] = ~act;
        rd = {rd[6:0], miso_v[i]};
        wait_clk(H);
        sck_v[i] = act;
      end else begin
        sck_v[i]  = ~act;
        mosi_v[i] = wr[7-b];
        wait_clk(H);
        sck_v[i] = act;
        rd = {rd[6:0], miso_v[i]};
        wait_clk(H);
      end
    end
  endtask

  task automatic do_frame(input int i, input int n, input logic [0:8][7:0] wr,
                          output logic [0:8][7:0] rd);
    logic [7:0] b;
    rd = '0;
    cs_n_v[i] = 1'b0;
    wait_clk(H);
    for (int k = 0; k < n; k++) begin
      spi_byte(i, wr[k], 8, b);
      rd[k] = b;
    end
    wait_clk(H);
    cs_n_v[i] = 1'b1;
    wait_clk(H);
  endtask

  // Reference: bytes at index >= moment take queued bytes in order, else FF.
  function automatic vec_t model(input vec_t v);
    int j = 0;
    for (int k = 0; k < 9; k++) begin
      if (k < v.n && k >= v.mom && j < v.nfeed) begin
        v.exp[k] = v.fd[j];
        j++;
      end else begin
        v.exp[k] = 8'hFF;
      end
    end
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int i, s_sof, s_eof, s_rx, s_te, loads, takes;
    logic [0:8][7:0] rd;
    i = v.inst;
    loads = (i % 2 == 0) ? v.n + 1 : v.n;
    takes = (loads - v.mom > 0) ? loads - v.mom : 0;
    if (v.nfeed < takes) takes = v.nfeed;
    cur      = i;
    mom_v[i] = 24'(v.mom);
    feed_fd  = v.fd;
    feed_n   = v.nfeed;
    feed_en  = 1'b1;
    wait_clk(4);
    s_sof = sof_cnt[i]; s_eof = eof_cnt[i]; s_rx = rx_cnt[i]; s_te = te_rise[i];
    do_frame(i, v.n, v.wr, rd);
    feed_en = 1'b0;
    wait_clk(2);
    check({tag, "_sof"}, 32'(sof_cnt[i] - s_sof), 32'd1);
    check({tag, "_eof"}, 32'(eof_cnt[i] - s_eof), 32'd1);
    check({tag, "_nrx"}, 32'(rx_cnt[i] - s_rx), 32'(v.n));
    check({tag, "_terise"}, 32'(te_rise[i] - s_te), 32'(takes));
    check({tag, "_teend"}, 32'(te_v[i]), 32'd1);
    check({tag, "_flag"}, 32'(flag_v[i]), 32'd0);
    check({tag, "_misoidle"}, 32'(miso_v[i]), 32'd1);
    for (int k = 0; k < v.n; k++) begin
      check($sformatf("%s_rx%0d", tag, k), 32'(rx_log[i][(s_rx + k) % 128]), 32'(v.wr[k]));
      check($sformatf("%s_miso%0d", tag, k), 32'(rd[k]), 32'(v.exp[k]));
    end
  endtask

  vec_t vecs [8];

  initial begin
    logic [7:0] b;
    int s_sof, s_eof, s_rx;
    vec_t v;

    vecs[0] = '{inst: 1, n: 9,
                wr: {8'hF1, 8'h01, 8'h02, 8'h03, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04},
                mom: 0, nfeed: 0, fd: '0, exp: {9{8'hFF}}};
    vecs[1] = '{inst: 1, n: 8, wr: '0, mom: 0, nfeed: 8,
                fd:  {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h00},
                exp: {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hFF}};
    vecs[2] = '{inst: 1, n: 4, wr: {8'h11, 8'h22, 8'h33, 8'h44, 40'h0}, mom: 0, nfeed: 0,
                fd: '0, exp: {9{8'hFF}}};
    vecs[3] = '{inst: 1, n: 4, wr: '0, mom: 2, nfeed: 2, fd: {8'hAA, 8'hBB, 56'h0},
                exp: {8'hFF, 8'hFF, 8'hAA, 8'hBB, 40'hFF_FFFF_FFFF}};
    for (int m = 0; m < 4; m++) begin
      vecs[4+m] = '{inst: m, n: 2, wr: {8'hA5, 8'h3C, 56'h0}, mom: 0, nfeed: 2,
                    fd: {8'hA5, 8'h3C, 56'h0}, exp: {8'hA5, 8'h3C, 56'hFF_FFFF_FFFF_FFFF}};
    end

    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cs_n_v[i] = 1'b1;
      sck_v[i]  = (i >= 2);
      mosi_v[i] = 1'b0;
      mom_v[i]  = 24'd0;
    end
    wait_clk(3);
    check("rst_miso", 32'(miso_v[1]), 32'd1);
    check("rst_tx_empty", 32'(te_v[1]), 32'd1);
    check("rst_flag", 32'(flag_v[1]), 32'd0);
    check("rst_data", 32'(rx_data_v[1]), 32'd0);
    rst_n = 1'b1;
    wait_clk(8);

    for (int t = 0; t < 8; t++) begin
      run_vec(vecs[t], $sformatf("v%0d", t));
    end

    // Random frames on random modes against the reference model.
    for (int r = 0; r < 8; r++) begin
      v.inst  = int'($urandom_range(0, 3));
      v.n     = int'($urandom_range(1, 5));
      v.mom   = int'($urandom_range(0, 3));
      v.nfeed = int'($urandom_range(0, (v.n > v.mom) ? v.n - v.mom : 0));
      for (int k = 0; k < 9; k++) begin
        v.wr[k] = 8'($urandom);
        v.fd[k] = 8'($urandom);
      end
      v = model(v);
      run_vec(v, $sformatf("r%0d", r));
    end

    // Partial trailing byte is dropped without a vld pulse.
    s_rx = rx_cnt[1]; s_eof = eof_cnt[1];
    cs_n_v[1] = 1'b0;
    wait_clk(H);
    spi_byte(1, 8'hC3, 8, b);
    spi_byte(1, 8'hFF, 3, b);
    wait_clk(H);
    cs_n_v[1] = 1'b1;
    wait_clk(H);
    check("part_nrx", 32'(rx_cnt[1] - s_rx), 32'd1);
    check("part_byte", 32'(rx_log[1][s_rx % 128]), 32'hC3);
    check("part_eof", 32'(eof_cnt[1] - s_eof), 32'd1);

    // Reset mid-byte aborts the frame without an eof.
    s_sof = sof_cnt[1]; s_eof = eof_cnt[1];
    cs_n_v[1] = 1'b0;
    wait_clk(H);
    spi_byte(1, 8'hF0, 4, b);
    rst_n = 1'b0;
    wait_clk(2);
    check("mid_rst_miso", 32'(miso_v[1]), 32'd1);
    check("mid_rst_tx_empty", 32'(te_v[1]), 32'd1);
    check("mid_rst_flag", 32'(flag_v[1]), 32'd0);
    check("mid_rst_vld", 32'(vld_v[1]), 32'd0);
    check("mid_rst_sof", 32'(sof_v[1]), 32'd0);
    check("mid_rst_eof", 32'(eof_v[1]), 32'd0);
    check("mid_rst_data", 32'(rx_data_v[1]), 32'd0);
    cs_n_v[1] = 1'b1;
    mosi_v[1] = 1'b0;
    wait_clk(2);
    rst_n = 1'b1;
    wait_clk(2 * H);
    check("post_rst_no_eof", 32'(eof_cnt[1] - s_eof), 32'd1 - 32'd1);
    check("post_rst_sof", 32'(sof_cnt[1] - s_sof), 32'd1);
    v = '{inst: 1, n: 1, wr: {8'h55, 64'h0}, mom: 0, nfeed: 0, fd: '0, exp: {9{8'hFF}}};
    run_vec(v, "after_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
